// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared constants and scheduler state encoding for the conv datapath
//
// Purpose: single source for the kernel edge and datapath widths so the
// scheduler, window counter and conv engine agree on K.
package conv_pkg;

  localparam int K     = 5;
  localparam int DIM_W = 8;
  localparam int ACC_W = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    KICK  = 3'd2,
    WAIT  = 3'd3,
    HOLD  = 3'd4,
    DRAIN = 3'd5
  } sched_state_t;

endpackage

// File: rtl/conv_win_counter.sv
// rtl/conv_win_counter.sv - raster-order row/col walker over the output map
//
// Purpose: tracks the current output position (row, col) of a frame.
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   clear_i     : return to (0,0); wins over advance_i
//   advance_i   : step to the next raster position
//   ow_i, oh_i  : output map width / height (both >= 1)
//   row_o/col_o : current position
//   is_last_o   : current position is (oh_i-1, ow_i-1)
module conv_win_counter #(
  parameter int DIM_W = conv_pkg::DIM_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             advance_i,
  input  logic [DIM_W-1:0] ow_i,
  input  logic [DIM_W-1:0] oh_i,
  output logic [DIM_W-1:0] row_o,
  output logic [DIM_W-1:0] col_o,
  output logic             is_last_o
);

  localparam logic [DIM_W-1:0] ONE = DIM_W'(1);

  logic [DIM_W-1:0] row_q, row_d;
  logic [DIM_W-1:0] col_q, col_d;
  logic             col_end;
  logic             row_end;

  assign col_end   = (col_q == ow_i - ONE);
  assign row_end   = (row_q == oh_i - ONE);
  assign is_last_o = row_end && col_end;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear_i) begin
      row_d = '0;
      col_d = '0;
    end else if (advance_i) begin
      if (is_last_o) begin
        // Wrap to the origin so the counter is clean for the next frame.
        row_d = '0;
        col_d = '0;
      end else if (col_end) begin
        col_d = '0;
        row_d = row_q + ONE;
      end else begin
        col_d = col_q + ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_o = row_q;
  assign col_o = col_q;

endmodule

// File: rtl/conv_frame_sched.sv
// rtl/conv_frame_sched.sv - raster-order frame scheduler for the KxK conv engine
//
// Purpose: walks every output position of a frame, requests each window,
// kicks the conv engine, and streams results out through a one-entry
// holding register with coordinates and a last flag.
// Ports:
//   clk, rst_n                       : clock, async active-low reset
//   cfg_start, cfg_img_w, cfg_img_h  : frame start and input dims (IDLE only)
//   abort                            : drop the frame, back to IDLE
//   busy, frame_done, cfg_err        : frame status
//   win_req/win_row/win_col, win_ack : window loader handshake
//   conv_start, conv_done, conv_result : engine handshake
//   out_valid/out_ready/out_data/out_row/out_col/out_last : result stream
module conv_frame_sched #(
  parameter int K     = conv_pkg::K,
  parameter int DIM_W = conv_pkg::DIM_W,
  parameter int ACC_W = conv_pkg::ACC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_start,
  input  logic [DIM_W-1:0] cfg_img_w,
  input  logic [DIM_W-1:0] cfg_img_h,
  input  logic             abort,
  output logic             busy,
  output logic             frame_done,
  output logic             cfg_err,
  output logic             win_req,
  output logic [DIM_W-1:0] win_row,
  output logic [DIM_W-1:0] win_col,
  input  logic             win_ack,
  output logic             conv_start,
  input  logic             conv_done,
  input  logic [ACC_W-1:0] conv_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [DIM_W-1:0] out_row,
  output logic [DIM_W-1:0] out_col,
  output logic             out_last
);

  import conv_pkg::sched_state_t;
  import conv_pkg::IDLE;
  import conv_pkg::FETCH;
  import conv_pkg::KICK;
  import conv_pkg::WAIT;
  import conv_pkg::HOLD;
  import conv_pkg::DRAIN;

  localparam logic [DIM_W-1:0] K_DIM = DIM_W'(K);
  localparam logic [DIM_W-1:0] ONE   = DIM_W'(1);

  sched_state_t     state_q, state_d;
  logic [DIM_W-1:0] ow_q, oh_q;
  logic             full_q;
  logic [ACC_W-1:0] out_data_q;
  logic [DIM_W-1:0] out_row_q, out_col_q;
  logic             out_last_q;
  logic             cfg_err_q;
  logic             frame_done_q;

  logic [DIM_W-1:0] pos_row, pos_col;
  logic             pos_last;
  logic             dims_ok, start_ok, kill, xfer, room, load;

  assign dims_ok  = (cfg_img_w >= K_DIM) && (cfg_img_h >= K_DIM);
  assign start_ok = (state_q == IDLE) && cfg_start && dims_ok;
  assign kill     = (state_q != IDLE) && abort;
  assign xfer     = full_q && out_ready;
  // The holding register can take a new result if it is empty or its beat
  // leaves this very cycle.
  assign room     = !full_q || out_ready;
  // HOLD captures the still-stable engine result once room appears.
  assign load     = (((state_q == WAIT) && conv_done) || (state_q == HOLD))
                    && room && !kill;

  conv_win_counter #(
    .DIM_W (DIM_W)
  ) u_win_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (start_ok || kill),
    .advance_i (load),
    .ow_i      (ow_q),
    .oh_i      (oh_q),
    .row_o     (pos_row),
    .col_o     (pos_col),
    .is_last_o (pos_last)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (kill) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start_ok) state_d = FETCH;
        FETCH:   if (win_ack) state_d = KICK;
        KICK:    state_d = WAIT;
        WAIT: begin
          if (conv_done) begin
            if (!room)         state_d = HOLD;
            else if (pos_last) state_d = DRAIN;
            else               state_d = FETCH;
          end
        end
        HOLD: begin
          if (room) state_d = pos_last ? DRAIN : FETCH;
        end
        DRAIN:   if (xfer) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Moore outputs
  always_comb begin
    win_req    = 1'b0;
    conv_start = 1'b0;
    busy       = (state_q != IDLE);
    case (state_q)
      FETCH:   win_req = 1'b1;
      KICK:    conv_start = 1'b1;
      default: ;
    endcase
  end

  // Frame dims, holding register and status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ow_q         <= '0;
      oh_q         <= '0;
      full_q       <= 1'b0;
      out_data_q   <= '0;
      out_row_q    <= '0;
      out_col_q    <= '0;
      out_last_q   <= 1'b0;
      cfg_err_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      cfg_err_q    <= (state_q == IDLE) && cfg_start && !dims_ok;
      frame_done_q <= (state_q == DRAIN) && xfer && !kill;
      if (start_ok) begin
        ow_q <= cfg_img_w - K_DIM + ONE;
        oh_q <= cfg_img_h - K_DIM + ONE;
      end
      if (kill) begin
        full_q <= 1'b0;
      end else if (load) begin
        full_q <= 1'b1;
      end else if (xfer) begin
        full_q <= 1'b0;
      end
      if (load) begin
        out_data_q <= conv_result;
        out_row_q  <= pos_row;
        out_col_q  <= pos_col;
        out_last_q <= pos_last;
      end
    end
  end

  assign cfg_err    = cfg_err_q;
  assign frame_done = frame_done_q;
  assign win_row    = pos_row;
  assign win_col    = pos_col;
  assign out_valid  = full_q;
  assign out_data   = out_data_q;
  assign out_row    = out_row_q;
  assign out_col    = out_col_q;
  assign out_last   = out_last_q;

endmodule

// File: tb/tb_conv_frame_sched.sv
// tb/tb_conv_frame_sched.sv - directed bench for conv_frame_sched
module tb_conv_frame_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_start;
  logic [7:0]  cfg_img_w, cfg_img_h;
  logic        abort;
  logic        busy, frame_done, cfg_err;
  logic        win_req;
  logic [7:0]  win_row, win_col;
  logic        win_ack = 1'b0;
  logic        conv_start;
  logic        conv_done = 1'b0;
  logic [31:0] conv_result = '0;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [7:0]  out_row, out_col;
  logic        out_last;

  always #5 clk = ~clk;

  conv_frame_sched dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_start   (cfg_start),
    .cfg_img_w   (cfg_img_w),
    .cfg_img_h   (cfg_img_h),
    .abort       (abort),
    .busy        (busy),
    .frame_done  (frame_done),
    .cfg_err     (cfg_err),
    .win_req     (win_req),
    .win_row     (win_row),
    .win_col     (win_col),
    .win_ack     (win_ack),
    .conv_start  (conv_start),
    .conv_done   (conv_done),
    .conv_result (conv_result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_row     (out_row),
    .out_col     (out_col),
    .out_last    (out_last)
  );

  // Window loader acks one cycle after the request; engine answers 25 cycles
  // after its start with row*10+col of the window it was started on.
  int          eng_cnt = 0;
  logic [31:0] eng_tag = '0;
  always @(negedge clk) begin
    win_ack   = win_req && !win_ack;
    conv_done = 1'b0;
    if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        conv_done   = 1'b1;
        conv_result = eng_tag;
      end
    end
    if (conv_start) begin
      eng_cnt = 25;
      eng_tag = 32'(win_row) * 10 + 32'(win_col);
    end
  end

  typedef struct {
    logic [7:0]  row;
    logic [7:0]  col;
    logic [31:0] data;
    logic        last;
    int          cyc;
  } beat_t;

  beat_t beats[$];
  int    cyc = 0;
  int    n_start, n_done, n_err, n_req, n_busy;
  int    first_req_cyc, first_valid_cyc, done_cyc;
  logic  prev_req = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (out_valid && out_ready)
      beats.push_back('{row: out_row, col: out_col, data: out_data, last: out_last, cyc: cyc});
    if (conv_start) n_start++;
    if (frame_done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (cfg_err) n_err++;
    if (busy) n_busy++;
    if (win_req && !prev_req) n_req++;
    if (win_req && first_req_cyc < 0) first_req_cyc = cyc;
    if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    prev_req = win_req;
  end

  int n_vec = 0;
  int n_miss = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_mon();
    beats.delete();
    n_start = 0; n_done = 0; n_err = 0; n_req = 0; n_busy = 0;
    first_req_cyc = -1; first_valid_cyc = -1; done_cyc = -1;
  endtask

  task automatic start_frame(input int w, input int h);
    cfg_img_w = 8'(w);
    cfg_img_h = 8'(h);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    cfg_img_w = '0;
    cfg_img_h = '0;
  endtask

  task automatic wait_frame(input string name);
    int to = 1;
    for (int i = 0; i < 3000; i++) begin
      if (n_done > 0 || n_err > 0) begin
        to = 0;
        break;
      end
      tick();
    end
    ticks(3);
    chk({name, "_timeout"}, 64'(to), 64'd0);
  endtask

  task automatic check_beats(input string name, input int ow, input int oh);
    int n = ow * oh;
    chk({name, "_beats"}, 64'(beats.size()), 64'(n));
    for (int i = 0; i < beats.size() && i < n; i++) begin
      int r = i / ow;
      int c = i % ow;
      chk($sformatf("%s_beat%0d", name, i),
          {15'd0, beats[i].row, beats[i].col, beats[i].data, beats[i].last},
          {15'd0, 8'(r), 8'(c), 32'(r * 10 + c), (i == n - 1)});
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_ctl"}, {57'd0, busy, frame_done, cfg_err, win_req, conv_start, out_valid, out_last}, 64'd0);
    chk({name, "_data"}, {32'd0, out_data}, 64'd0);
    chk({name, "_coord"}, {32'd0, out_row, out_col, win_row, win_col}, 64'd0);
  endtask

  typedef struct {
    int w;
    int h;
    int beats;
    int err;
    int last_data;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int stall_bad;
    int to;
    vecs[0] = '{w: 6, h: 6, beats: 4, err: 0, last_data: 11};
    vecs[1] = '{w: 5, h: 5, beats: 1, err: 0, last_data: 0};
    vecs[2] = '{w: 4, h: 7, beats: 0, err: 1, last_data: 0};
    vecs[3] = '{w: 7, h: 6, beats: 6, err: 0, last_data: 12};
    vecs[4] = '{w: 8, h: 5, beats: 4, err: 0, last_data: 3};
    vecs[5] = '{w: 5, h: 9, beats: 5, err: 0, last_data: 40};
    vecs[6] = '{w: 5, h: 4, beats: 0, err: 1, last_data: 0};

    rst_n = 1'b0; cfg_start = 1'b0; cfg_img_w = '0; cfg_img_h = '0;
    abort = 1'b0; out_ready = 1'b1;
    clear_mon();
    #2;
    chk_all_zero("reset");
    ticks(3);
    rst_n = 1'b1;
    ticks(2);

    for (int v = 0; v < 7; v++) begin
      string nm = $sformatf("vec%0d_%0dx%0d", v, vecs[v].w, vecs[v].h);
      clear_mon();
      start_frame(vecs[v].w, vecs[v].h);
      wait_frame(nm);
      chk({nm, "_cfg_err"}, 64'(n_err), 64'(vecs[v].err));
      chk({nm, "_frame_done"}, 64'(n_done), 64'(1 - vecs[v].err));
      chk({nm, "_win_reqs"}, 64'(n_req), 64'(vecs[v].beats));
      chk({nm, "_conv_starts"}, 64'(n_start), 64'(vecs[v].beats));
      chk({nm, "_busy_end"}, 64'(busy), 64'd0);
      if (vecs[v].err != 0) begin
        chk({nm, "_busy_cycles"}, 64'(n_busy), 64'd0);
        chk({nm, "_no_beats"}, 64'(beats.size()), 64'd0);
      end else begin
        check_beats(nm, vecs[v].w - 4, vecs[v].h - 4);
        if (beats.size() > 0) begin
          chk({nm, "_last_data"}, 64'(beats[beats.size()-1].data), 64'(vecs[v].last_data));
          // FETCH + KICK + 25 engine cycles before the first beat is valid.
          chk({nm, "_latency"}, 64'(first_valid_cyc - first_req_cyc), 64'd27);
          chk({nm, "_done_after_last"}, 64'(done_cyc - beats[beats.size()-1].cyc), 64'd1);
        end
      end
    end

    // Back-pressure on a 7x6 frame: beat 0 held, window 1 overlaps, then HOLD.
    clear_mon();
    out_ready = 1'b0;
    start_frame(7, 6);
    to = 1;
    for (int i = 0; i < 200; i++) begin
      if (out_valid) begin
        to = 0;
        break;
      end
      tick();
    end
    chk("bp_first_valid_timeout", 64'(to), 64'd0);
    stall_bad = 0;
    for (int i = 0; i < 60; i++) begin
      if (out_valid !== 1'b1 || out_data !== 32'd0 || out_row !== 8'd0 ||
          out_col !== 8'd0 || out_last !== 1'b0)
        stall_bad++;
      tick();
    end
    chk("bp_beat0_stable", 64'(stall_bad), 64'd0);
    chk("bp_starts_during_stall", 64'(n_start), 64'd2);
    chk("bp_no_fetch_in_hold", {62'd0, win_req, conv_start}, 64'd0);
    out_ready = 1'b1;
    wait_frame("bp");
    check_beats("bp", 3, 2);
    chk("bp_starts_total", 64'(n_start), 64'd6);
    chk("bp_frame_done", 64'(n_done), 64'd1);

    // Abort one cycle after the second conv_start of a 6x6 frame.
    clear_mon();
    start_frame(6, 6);
    to = 1;
    for (int i = 0; i < 200; i++) begin
      if (n_start >= 2) begin
        to = 0;
        break;
      end
      tick();
    end
    chk("abort_wait_timeout", 64'(to), 64'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_outputs", {61'd0, busy, out_valid, win_req}, 64'd0);
    ticks(40);
    chk("abort_late_done_no_beat", 64'(beats.size()), 64'd1);
    chk("abort_no_frame_done", 64'(n_done), 64'd0);
    clear_mon();
    start_frame(5, 5);
    wait_frame("after_abort");
    check_beats("after_abort", 1, 1);
    chk("after_abort_frame_done", 64'(n_done), 64'd1);

    // Asynchronous reset while the engine is busy.
    clear_mon();
    start_frame(6, 6);
    to = 1;
    for (int i = 0; i < 200; i++) begin
      if (n_start >= 1) begin
        to = 0;
        break;
      end
      tick();
    end
    chk("rst_wait_timeout", 64'(to), 64'd0);
    ticks(5);
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid_wait_reset");
    tick();
    rst_n = 1'b1;
    ticks(40);
    chk("rst_no_beats", 64'(beats.size()), 64'd0);
    chk("rst_no_frame_done", 64'(n_done), 64'd0);

    // Fresh frame with stray cfg_start pulses while busy.
    clear_mon();
    start_frame(6, 6);
    ticks(10);
    start_frame(5, 5);
    ticks(40);
    start_frame(9, 9);
    wait_frame("busy_start");
    check_beats("busy_start", 2, 2);
    chk("busy_start_frame_done", 64'(n_done), 64'd1);
    chk("busy_start_conv_starts", 64'(n_start), 64'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
